// File: rtl/glitc_corr_pkg.sv
// rtl/glitc_corr_pkg.sv - shared correlator types, widths and peak-finder FSM states
package glitc_corr_pkg;

    localparam int CORR_BITS = 11;
    localparam int NCORRS    = 4;

    typedef logic [CORR_BITS-1:0] corr_t;
    typedef logic [1:0]           corr_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        HOLD
    } state_t;

endpackage

// File: rtl/corr_max4.sv
// rtl/corr_max4.sv - registered unsigned max of four correlations, lowest index wins ties
module corr_max4
    import glitc_corr_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      in_valid,
    input  corr_t     corr0,
    input  corr_t     corr1,
    input  corr_t     corr2,
    input  corr_t     corr3,
    output logic      out_valid,
    output corr_t     out_value,
    output corr_idx_t out_index
);

    corr_t     best_value;
    corr_idx_t best_index;

    // Strict compares in ascending index order keep the lowest index on ties.
    always_comb begin
        best_value = corr0;
        best_index = 2'd0;
        if (corr1 > best_value) begin
            best_value = corr1;
            best_index = 2'd1;
        end
        if (corr2 > best_value) begin
            best_value = corr2;
            best_index = 2'd2;
        end
        if (corr3 > best_value) begin
            best_value = corr3;
            best_index = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_index <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_value <= best_value;
                out_index <= best_index;
            end
        end
    end

endmodule

// File: rtl/quad_corr_peak_finder.sv
// rtl/quad_corr_peak_finder.sv - windowed peak search over 4 correlations; QUAD_CORR_PEAK_THRESH_EN adds above-threshold count
module quad_corr_peak_finder #(
    parameter int NCORRS   = 4,
    parameter int CORRBITS = 11,
    parameter int WINDOW   = 64,
    parameter int CNTBITS  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      corr_valid,
    input  glitc_corr_pkg::corr_t     CORR0,
    input  glitc_corr_pkg::corr_t     CORR1,
    input  glitc_corr_pkg::corr_t     CORR2,
    input  glitc_corr_pkg::corr_t     CORR3,
`ifdef QUAD_CORR_PEAK_THRESH_EN
    input  glitc_corr_pkg::corr_t     threshold,
    output logic [CNTBITS:0]          above_count,
`endif
    output logic                      busy,
    output logic                      peak_valid,
    input  logic                      peak_ready,
    output glitc_corr_pkg::corr_t     peak_value,
    output glitc_corr_pkg::corr_idx_t peak_index,
    output logic [CNTBITS-1:0]        peak_offset
);

    import glitc_corr_pkg::*;

    if (NCORRS != glitc_corr_pkg::NCORRS || CORRBITS != CORR_BITS) begin : g_bad_corr_shape
        $error("quad_corr_peak_finder supports only 4 correlations of 11 bits");
    end
    if (WINDOW < 2 || WINDOW > (1 << CNTBITS)) begin : g_bad_window
        $error("quad_corr_peak_finder WINDOW must be in 2..2**CNTBITS");
    end

    localparam logic [CNTBITS-1:0] LAST_OFFSET = CNTBITS'(WINDOW - 1);

    state_t             state;
    state_t             state_next;
    logic [CNTBITS-1:0] cnt;
    logic               got_all;
    logic               take;
    logic               window_start;

    logic               s1_valid;
    corr_t              s1_value;
    corr_idx_t          s1_index;
    logic [CNTBITS-1:0] s1_offset;
    logic               s1_last;

    corr_t              run_value;
    corr_idx_t          run_index;
    logic [CNTBITS-1:0] run_offset;
    logic               s2_last;

    assign window_start = (state == IDLE) && start;
    assign take         = (state == SEARCH) && corr_valid && !got_all;
    assign busy         = (state == SEARCH);
    assign peak_valid   = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = SEARCH;
            SEARCH:  if (s2_last)    state_next = HOLD;
            HOLD:    if (peak_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    corr_max4 u_corr_max4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (take),
        .corr0     (CORR0),
        .corr1     (CORR1),
        .corr2     (CORR2),
        .corr3     (CORR3),
        .out_valid (s1_valid),
        .out_value (s1_value),
        .out_index (s1_index)
    );

    // s1_last/s2_last track the final sample through the two pipeline stages;
    // the result register loads one edge after the final merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            got_all     <= 1'b0;
            s1_offset   <= '0;
            s1_last     <= 1'b0;
            s2_last     <= 1'b0;
            run_value   <= '0;
            run_index   <= '0;
            run_offset  <= '0;
            peak_value  <= '0;
            peak_index  <= '0;
            peak_offset <= '0;
        end else begin
            s1_last <= take && (cnt == LAST_OFFSET);
            s2_last <= s1_valid && s1_last;
            if (take) begin
                s1_offset <= cnt;
            end
            if (window_start) begin
                cnt        <= '0;
                got_all    <= 1'b0;
                run_value  <= '0;
                run_index  <= '0;
                run_offset <= '0;
            end else begin
                if (take) begin
                    got_all <= (cnt == LAST_OFFSET);
                    if (cnt != LAST_OFFSET) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (s1_valid && (s1_value > run_value)) begin
                    run_value  <= s1_value;
                    run_index  <= s1_index;
                    run_offset <= s1_offset;
                end
            end
            if ((state == SEARCH) && s2_last) begin
                peak_value  <= run_value;
                peak_index  <= run_index;
                peak_offset <= run_offset;
            end
        end
    end

`ifdef QUAD_CORR_PEAK_THRESH_EN
    logic s1_above;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_above    <= 1'b0;
            above_count <= '0;
        end else begin
            s1_above <= take && ((CORR0 > threshold) || (CORR1 > threshold) ||
                                 (CORR2 > threshold) || (CORR3 > threshold));
            if (window_start) begin
                above_count <= '0;
            end else if (s1_above) begin
                above_count <= above_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quad_corr_peak_finder.sv
// tb/tb_quad_corr_peak_finder.sv - scoreboard bench for quad_corr_peak_finder (QUAD_CORR_PEAK_THRESH_EN aware)
module tb_quad_corr_peak_finder;

    localparam int WIN  = 64;
    localparam int CNTB = 8;

    typedef struct {
        int value;
        int index;
        int offset;
        int above;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            corr_valid = 1'b0;
    logic            peak_ready = 1'b0;
    logic [10:0]     corr [4];
    logic [10:0]     threshold = 11'd2047;
    logic            busy;
    logic            peak_valid;
    logic [10:0]     peak_value;
    logic [1:0]      peak_index;
    logic [CNTB-1:0] peak_offset;
`ifdef QUAD_CORR_PEAK_THRESH_EN
    logic [CNTB:0]   above_count;
`endif

    exp_t exp_q[$];
    int   smp [4][WIN];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    quad_corr_peak_finder #(
        .NCORRS(4), .CORRBITS(11), .WINDOW(WIN), .CNTBITS(CNTB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .corr_valid  (corr_valid),
        .CORR0       (corr[0]),
        .CORR1       (corr[1]),
        .CORR2       (corr[2]),
        .CORR3       (corr[3]),
`ifdef QUAD_CORR_PEAK_THRESH_EN
        .threshold   (threshold),
        .above_count (above_count),
`endif
        .busy        (busy),
        .peak_valid  (peak_valid),
        .peak_ready  (peak_ready),
        .peak_value  (peak_value),
        .peak_index  (peak_index),
        .peak_offset (peak_offset)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_corr(input int v);
        for (int k = 0; k < 4; k++) corr[k] = 11'(v);
    endtask

    task automatic fill(input int v);
        for (int s = 0; s < WIN; s++)
            for (int k = 0; k < 4; k++) smp[k][s] = v;
    endtask

    task automatic fill_random();
        for (int s = 0; s < WIN; s++)
            for (int k = 0; k < 4; k++) smp[k][s] = int'($urandom_range(0, 2046));
    endtask

    // Garbage of 2047 is driven on every cycle that must not be sampled; real data stays below it.
    task automatic drive_window(input bit toggle, input bit extra_start, input bit lat_chk);
        exp_t e;
        e.value = 0; e.index = 0; e.offset = 0; e.above = 0;
        for (int s = 0; s < WIN; s++) begin
            bit any_above = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (smp[k][s] > e.value) begin
                    e.value = smp[k][s]; e.index = k; e.offset = s;
                end
                if (smp[k][s] > int'(threshold)) any_above = 1'b1;
            end
            if (any_above) e.above++;
        end
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1; corr_valid = 1'b1; set_corr(2047);
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < WIN; s++) begin
            if (toggle && s > 0) begin
                corr_valid = 1'b0; set_corr(2047); start = extra_start;
                @(negedge clk);
                start = 1'b0;
            end
            corr_valid = 1'b1;
            for (int k = 0; k < 4; k++) corr[k] = 11'(smp[k][s]);
            @(negedge clk);
        end
        corr_valid = 1'b0; set_corr(2047);
        if (lat_chk) begin
            check("lat_edge0_valid", peak_valid, 0);
            check("lat_edge0_busy", busy, 1);
            @(negedge clk);
            check("lat_edge1_valid", peak_valid, 0);
            @(negedge clk);
            check("lat_edge2_valid", peak_valid, 1);
            check("lat_edge2_busy", busy, 0);
        end
    endtask

    task automatic collect(input bit hold_test);
        exp_t e;
        int   t = 0;
        while (!peak_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!peak_valid) begin
            check("result_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check("peak_value", peak_value, e.value);
        check("peak_index", peak_index, e.index);
        check("peak_offset", peak_offset, e.offset);
`ifdef QUAD_CORR_PEAK_THRESH_EN
        check("above_count", above_count, e.above);
`endif
        if (hold_test) begin
            for (int i = 0; i < 20; i++) begin
                start = (i % 2 == 1);
                @(negedge clk);
                check("hold_valid", peak_valid, 1);
                check("hold_busy", busy, 0);
                check("hold_value", peak_value, e.value);
                check("hold_offset", peak_offset, e.offset);
            end
            start = 1'b1; peak_ready = 1'b1;
            @(negedge clk);
            start = 1'b0; peak_ready = 1'b0;
            check("accept_valid", peak_valid, 0);
            check("accept_busy", busy, 0);
            @(negedge clk);
            check("start_ignored_busy", busy, 0);
        end else begin
            peak_ready = 1'b1;
            @(negedge clk);
            peak_ready = 1'b0;
            check("accept_valid", peak_valid, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_corr(0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_peak_valid", peak_valid, 0);
        check("rst_peak_value", peak_value, 0);
        check("rst_peak_index", peak_index, 0);
        check("rst_peak_offset", peak_offset, 0);
`ifdef QUAD_CORR_PEAK_THRESH_EN
        check("rst_above_count", above_count, 0);
`endif
        rst_n = 1'b1;

        fill(5); smp[2][37] = 700;
        drive_window(1'b0, 1'b0, 1'b1);
        collect(1'b0);

        fill(5); smp[1][3] = 900; smp[3][3] = 900; smp[0][50] = 900;
        drive_window(1'b0, 1'b0, 1'b0);
        collect(1'b0);

        fill_random();
        drive_window(1'b1, 1'b1, 1'b1);
        collect(1'b0);

        fill_random();
        drive_window(1'b0, 1'b0, 1'b0);
        collect(1'b1);

        fill(0);
        drive_window(1'b0, 1'b0, 1'b0);
        collect(1'b0);

        fill(5); smp[3][WIN-1] = 2046;
        drive_window(1'b0, 1'b0, 1'b0);
        collect(1'b0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; corr_valid = 1'b1; set_corr(2000);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_peak_valid", peak_valid, 0);
        check("midrst_peak_value", peak_value, 0);
        check("midrst_peak_offset", peak_offset, 0);
        @(negedge clk);
        rst_n = 1'b1; corr_valid = 1'b0;
        fill(5); smp[0][12] = 321;
        drive_window(1'b0, 1'b0, 1'b1);
        collect(1'b0);

        for (int r = 0; r < 2; r++) begin
            fill_random();
            drive_window(1'b0, 1'b0, 1'b0);
            collect(1'b0);
        end

`ifdef QUAD_CORR_PEAK_THRESH_EN
        threshold = 11'd400;
        fill(5);
        smp[0][2] = 401;  smp[1][9] = 650;  smp[2][17] = 999;  smp[3][20] = 401;
        smp[0][33] = 1200; smp[3][33] = 800; smp[1][40] = 402; smp[2][55] = 700;
        smp[3][60] = 500; smp[1][61] = 400;
        drive_window(1'b0, 1'b0, 1'b0);
        collect(1'b0);
        threshold = 11'd2047;
`endif

        check("scoreboard_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
